pixel_frame_sink: RTL

- Captures the filtered pixel stream (o_strb/o_data from the 2D filter top) into a double-buffered frame memory.
- Exposes completed frames to a host or readback port with a release handshake.
- Sits downstream of the filter core and replaces file-based output capture when the design is built as an SoC.
- Writer fills one bank while the reader drains the other; whole frames that arrive with no free bank are dropped and flagged.

---
 rtl/pix_stream_pkg.sv | 19 +
 rtl/frame_bank_ram.sv | 36 +++
 rtl/pixel_frame_sink.sv | 136 +++++++++++++
 3 files changed

// File: rtl/pix_stream_pkg.sv
// Shared constants and encodings for the pixel stream capture path.
package pix_stream_pkg;

  localparam int IMG_W_DEF = 256;
  localparam int IMG_H_DEF = 256;
  localparam int DW_DEF    = 8;
  localparam int FRAME_PIX = IMG_W_DEF * IMG_H_DEF;

  typedef enum logic {
    WRITE = 1'b0,
    DROP  = 1'b1
  } wr_state_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } bank_state_t;

endpackage

// File: rtl/frame_bank_ram.sv
// Two-bank frame store: one write port and one registered read port, address {bank, pixel}.
module frame_bank_ram
  import pix_stream_pkg::*;
#(
  parameter int DW  = DW_DEF,
  parameter int BAW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [BAW:0]  waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [BAW:0]  raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(2**(BAW+1))-1];

  // write port, contents deliberately not reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // read register; reset so the read data output starts at zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/pixel_frame_sink.sv
// Double-buffered frame capture: the writer fills one bank while the host drains the other;
// whole frames arriving with no free bank are dropped and flagged in overflow.
module pixel_frame_sink
  import pix_stream_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int DW    = DW_DEF,
  parameter int AW    = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_strb,
  input  logic [DW-1:0] i_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  input  logic          rd_release,
  output logic          frame_avail,
  output logic          frame_done,
  output logic [7:0]    frame_cnt,
  output logic          overflow,
  input  logic          clr_ovf
);

  localparam int NPIX = IMG_W * IMG_H;
  localparam int PAW  = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);
  localparam logic [AW:0]   NPIX_EXT  = (AW+1)'(NPIX);

  wr_state_t     state;
  bank_state_t   bank_st [2];
  logic          wr_bank;
  logic          rd_bank;
  logic [AW-1:0] wr_addr;
  logic          oob;
  logic [DW-1:0] ram_q;

  logic rel, rd_ok, rd_in_range, free_any, free_bank;
  logic store, tgt_bank, other, last_pix, other_free;

  // bank bookkeeping: a dropping writer may resume only at a frame boundary
  always_comb begin
    frame_avail = (bank_st[rd_bank] == FULL);
    rel         = rd_release && frame_avail;
    rd_ok       = rd_en && frame_avail;
    rd_in_range = ({1'b0, rd_addr} < NPIX_EXT);
    free_any    = (bank_st[0] == EMPTY) || (bank_st[1] == EMPTY);
    free_bank   = (bank_st[rd_bank] == EMPTY) ? rd_bank : ~rd_bank;
    if (state == WRITE) begin
      store    = 1'b1;
      tgt_bank = wr_bank;
    end else begin
      store    = (wr_addr == '0) && free_any;
      tgt_bank = free_bank;
    end
    other      = ~tgt_bank;
    last_pix   = (wr_addr == LAST_ADDR);
    other_free = (bank_st[other] == EMPTY) || (rel && (rd_bank == other));
  end

  // write FSM, counters, flags and read-side registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= WRITE;
      bank_st[0] <= EMPTY;
      bank_st[1] <= EMPTY;
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
      wr_addr    <= '0;
      oob        <= 1'b0;
      rd_valid   <= 1'b0;
      frame_done <= 1'b0;
      frame_cnt  <= 8'd0;
      overflow   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      rd_valid   <= rd_ok;
      if (rd_ok) begin
        oob <= !rd_in_range;
      end
      if (rel) begin
        bank_st[rd_bank] <= EMPTY;
        rd_bank          <= ~rd_bank;
      end
      if (clr_ovf) begin
        overflow <= 1'b0;
      end
      if (i_strb) begin
        if (store) begin
          if (last_pix) begin
            bank_st[tgt_bank] <= FULL;
            wr_addr           <= '0;
            frame_done        <= 1'b1;
            frame_cnt         <= frame_cnt + 8'd1;
            if (other_free) begin
              wr_bank <= other;
              state   <= WRITE;
            end else begin
              wr_bank <= tgt_bank;
              state   <= DROP;
            end
          end else begin
            wr_addr <= wr_addr + AW'(1);
            wr_bank <= tgt_bank;
            state   <= WRITE;
          end
        end else begin
          // first pixel of a frame that has nowhere to go
          if (wr_addr == '0) begin
            overflow <= 1'b1;
          end
          wr_addr <= last_pix ? '0 : wr_addr + AW'(1);
        end
      end
    end
  end

  assign rd_data = oob ? '0 : ram_q;

  frame_bank_ram #(
    .DW  (DW),
    .BAW (PAW)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (i_strb && store),
    .waddr ({tgt_bank, wr_addr[PAW-1:0]}),
    .wdata (i_data),
    .re    (rd_ok && rd_in_range),
    .raddr ({rd_bank, rd_addr[PAW-1:0]}),
    .rdata (ram_q)
  );

endmodule
